// File: rtl/axi_pkg.sv
// Shared AXI constants and read-responder FSM state encoding.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_rdata_skid.sv
// Two-entry FIFO holding R beats {last, resp, data}; push and pop may coincide.
module axi_rdata_skid #(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  // Shift the tail forward on pop; new data lands in the first free slot
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 tail_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/axi_slave_read_channel.sv
// AXI4 read responder: one INCR burst at a time from a 1-cycle-latency memory port.
module axi_slave_read_channel
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned READ_CHANNEL_WIDTH = 32,
  parameter int unsigned READ_BURST_LEN     = 8,
  parameter int unsigned MEM_ADDR_WIDTH     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ARVALID,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic [READ_BURST_LEN-1:0]     ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  output logic                          ARREADY,
  output logic                          RVALID,
  output logic [READ_CHANNEL_WIDTH-1:0] RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  input  logic                          RREADY,
  output logic                          mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [READ_CHANNEL_WIDTH-1:0] mem_rdata
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W   = READ_BURST_LEN + 1;
  localparam int unsigned DW      = READ_CHANNEL_WIDTH;
  localparam int unsigned ENTRY_W = DW + 3;

  rd_state_e          state_q, state_d;
  logic [WORD_AW-1:0] waddr_q, waddr_d;
  logic [CNT_W-1:0]   issue_left_q, issue_left_d;
  logic               err_q, err_d;
  logic               inflight_q, inflight_last_q, inflight_err_q;

  logic               ar_ready_c, issue_c, oor_c, beat_err_c, r_last_fire_c;
  logic               skid_empty_c, skid_push_c, skid_pop_c, head_valid_c;
  logic [1:0]         skid_count;
  logic [ENTRY_W-1:0] skid_head, in_entry_c, head_entry_c;
  logic [DW-1:0]      in_data_c;
  logic [1:0]         in_resp_c;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^ARADDR[1:0];

  // Issue gating: a beat needs a free slot counting the read already in flight
  assign ar_ready_c = (state_q == IDLE) && !rst;
  assign oor_c      = (waddr_q >> MEM_ADDR_WIDTH) != '0;
  assign beat_err_c = err_q || oor_c;
  assign issue_c    = (state_q == BURST) && (issue_left_q != '0) && !rst &&
                      (({1'b0, skid_count} + {2'b00, inflight_q}) < 3'd2);

  assign ARREADY   = ar_ready_c;
  assign mem_ren   = issue_c && !beat_err_c;
  assign mem_raddr = waddr_q[MEM_ADDR_WIDTH-1:0];

  // Beat returning this cycle; error beats carry zero data
  assign in_data_c  = inflight_err_q ? '0 : mem_rdata;
  assign in_resp_c  = inflight_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign in_entry_c = {inflight_last_q, in_resp_c, in_data_c};

  // Empty FIFO flows the returning beat straight through to R
  assign skid_empty_c = (skid_count == 2'd0);
  assign head_valid_c = !skid_empty_c || inflight_q;
  assign head_entry_c = skid_empty_c ? in_entry_c : skid_head;
  assign skid_pop_c   = !skid_empty_c && RREADY;
  assign skid_push_c  = inflight_q && !(skid_empty_c && RREADY);

  assign RVALID = head_valid_c && !rst;
  assign RDATA  = RVALID ? head_entry_c[DW-1:0] : '0;
  assign RRESP  = RVALID ? head_entry_c[DW+1:DW] : AXI_RESP_OKAY;
  assign RLAST  = RVALID && head_entry_c[DW+2];

  assign r_last_fire_c = RVALID && RREADY && RLAST;

  axi_rdata_skid #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push_c),
    .din_i   (in_entry_c),
    .pop_i   (skid_pop_c),
    .head_o  (skid_head),
    .count_o (skid_count)
  );

  // Next-state: accept AR in IDLE, walk the address while issuing in BURST
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    issue_left_d = issue_left_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (ARVALID && ar_ready_c) begin
          waddr_d      = ARADDR[ADDR_WIDTH-1:2];
          issue_left_d = CNT_W'(ARLEN) + CNT_W'(1);
          err_d        = (ARSIZE != AXI_SIZE_4B) || (ARBURST != AXI_BURST_INCR);
          state_d      = BURST;
        end
      end
      BURST: begin
        if (issue_c) begin
          waddr_d      = waddr_q + WORD_AW'(1);
          issue_left_d = issue_left_q - CNT_W'(1);
        end
        if (r_last_fire_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and in-flight beat tags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      waddr_q         <= '0;
      issue_left_q    <= '0;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      waddr_q         <= waddr_d;
      issue_left_q    <= issue_left_d;
      err_q           <= err_d;
      inflight_q      <= issue_c;
      inflight_last_q <= (issue_left_q == CNT_W'(1));
      inflight_err_q  <= beat_err_c;
    end
  end

endmodule

// File: tb/tb_axi_slave_read_channel.sv
// Bench for axi_slave_read_channel: burst-level reference model plus directed bursts.
module tb_axi_slave_read_channel;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 8;
  localparam int unsigned MAW = 10;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ARVALID;
  logic [AW-1:0] ARADDR;
  logic [LW-1:0] ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARREADY;
  logic          RVALID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RREADY;
  logic          mem_ren;
  logic [MAW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t      exp_q[$];
  logic [9:0] ren_q[$];
  beat_t      log_q[$];
  bit         m_in_burst = 0;
  int         hs_cyc = 0;
  int         last_fire_cyc = 0;
  int         pend = 0;

  axi_slave_read_channel dut (
    .clk       (clk),
    .rst       (rst),
    .ARVALID   (ARVALID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARREADY   (ARREADY),
    .RVALID    (RVALID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RREADY    (RREADY),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears the cycle after the read strobe
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected beat list for one burst from the AXI rules
  function automatic void build(input logic [31:0] a, input logic [7:0] len,
                                input logic [2:0] sz, input logic [1:0] bt);
    bit ferr = (sz != 3'b010) || (bt != 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] w;
      beat_t b;
      w   = (a >> 2) + 32'(i);
      b.l = (i == int'(len));
      if (ferr || (w >= 32'd1024)) begin
        b.d = '0;
        b.r = 2'b10;
      end else begin
        b.d = mem[w[9:0]];
        b.r = 2'b00;
        ren_q.push_back(w[9:0]);
      end
      exp_q.push_back(b);
    end
  endfunction

  // Per-cycle compare of DUT against the model
  always @(negedge clk) begin
    beat_t cur;
    logic  exp_v;
    if (rst) begin
      chk("rst_outputs", {ARREADY, RVALID, RLAST, mem_ren, RRESP, RDATA}, '0);
      exp_q.delete();
      ren_q.delete();
      m_in_burst = 0;
      pend = 0;
    end else begin
      chk("arready", ARREADY, !m_in_burst);
      exp_v = m_in_burst && (cyc >= hs_cyc + 2);
      chk("rvalid", RVALID, exp_v);
      if (RVALID && exp_q.size() > 0) begin
        cur = exp_q[0];
        chk("rdata", RDATA, cur.d);
        chk("rresp", RRESP, cur.r);
        chk("rlast", RLAST, cur.l);
        if (RREADY) begin
          void'(exp_q.pop_front());
          log_q.push_back({RDATA, RRESP, RLAST});
          if (cur.r == 2'b00) pend--;
          if (cur.l) begin
            m_in_burst = 0;
            last_fire_cyc = cyc;
          end
        end
      end
      if (mem_ren) begin
        chk("ren_pending", pend < 2, 1'b1);
        if (ren_q.size() == 0) chk("ren_unexpected", mem_ren, 1'b0);
        else                   chk("raddr", mem_raddr, ren_q.pop_front());
        pend++;
      end
      if (ARVALID && ARREADY) begin
        build(ARADDR, ARLEN, ARSIZE, ARBURST);
        m_in_burst = 1;
        hs_cyc = cyc;
      end
    end
  end

  task automatic start_ar(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    bit hs = 0;
    int t = 0;
    ARVALID = 1'b1; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; RREADY = 1'b1;
    while (!hs && t < 20) begin
      @(negedge clk);
      hs = ARREADY;
      @(posedge clk); #1;
      t++;
    end
    ARVALID = 1'b0;
    chk("ar_handshake", hs, 1'b1);
  endtask

  task automatic drain(input logic [15:0] p, input int n);
    int k = 0;
    int t = 0;
    while (m_in_burst && t < 200) begin
      @(posedge clk); #1;
      RREADY = (k < n) ? p[k] : 1'b1;
      k++;
      t++;
    end
    RREADY = 1'b1;
    chk("drain_done", m_in_burst, 1'b0);
  endtask

  task automatic lit(input string nm, input int idx, input logic [31:0] d,
                     input logic [1:0] r, input logic l);
    if (idx < log_q.size()) chk(nm, log_q[idx], {d, r, l});
    else                    chk({nm, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
  endtask

  initial begin
    int base;
    int l1;
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    rst = 1'b1; ARVALID = 1'b0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010;
    ARBURST = 2'b01; RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", ARREADY, 1'b1);
    chk("idle_rvalid", RVALID, 1'b0);
    @(posedge clk); #1;

    // 1: plain 4-beat burst at full throughput
    base = log_q.size();
    start_ar(32'h10, 8'd3, 3'b010, 2'b01);
    drain(16'h0, 0);
    chk("t1_count", 64'(log_q.size() - base), 64'd4);
    lit("t1_b0", base + 0, 32'hC0DE0004, 2'b00, 1'b0);
    lit("t1_b1", base + 1, 32'hC0DE0005, 2'b00, 1'b0);
    lit("t1_b2", base + 2, 32'hC0DE0006, 2'b00, 1'b0);
    lit("t1_b3", base + 3, 32'hC0DE0007, 2'b00, 1'b1);
    chk("t1_last_cycle", 64'(last_fire_cyc - hs_cyc), 64'd5);

    // 2: same burst under RREADY back-pressure
    base = log_q.size();
    start_ar(32'h10, 8'd3, 3'b010, 2'b01);
    drain(16'b1011001, 7);
    chk("t2_count", 64'(log_q.size() - base), 64'd4);
    lit("t2_b0", base + 0, 32'hC0DE0004, 2'b00, 1'b0);
    lit("t2_b3", base + 3, 32'hC0DE0007, 2'b00, 1'b1);

    // 3: single-beat bursts back to back
    base = log_q.size();
    start_ar(32'h20, 8'd0, 3'b010, 2'b01);
    drain(16'h0, 0);
    l1 = last_fire_cyc;
    start_ar(32'h40, 8'd0, 3'b010, 2'b01);
    chk("t3_b2b_accept", 64'(hs_cyc), 64'(l1 + 1));
    drain(16'h0, 0);
    lit("t3_b0", base + 0, 32'hC0DE0008, 2'b00, 1'b1);
    lit("t3_b1", base + 1, 32'hC0DE0010, 2'b00, 1'b1);

    // 4: non-INCR burst answers SLVERR without touching memory
    base = log_q.size();
    start_ar(32'h50, 8'd2, 3'b010, 2'b10);
    drain(16'b0110, 4);
    lit("t4_b0", base + 0, 32'h0, 2'b10, 1'b0);
    lit("t4_b1", base + 1, 32'h0, 2'b10, 1'b0);
    lit("t4_b2", base + 2, 32'h0, 2'b10, 1'b1);

    // 5: burst crossing the top of memory
    base = log_q.size();
    start_ar(32'hFFC, 8'd1, 3'b010, 2'b01);
    drain(16'h0, 0);
    lit("t5_b0", base + 0, 32'hC0DE03FF, 2'b00, 1'b0);
    lit("t5_b1", base + 1, 32'h0, 2'b10, 1'b1);

    // 6: reset after two beats of an 8-beat burst, then a fresh burst
    base = log_q.size();
    start_ar(32'h100, 8'd7, 3'b010, 2'b01);
    t = 0;
    while (log_q.size() < base + 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t6_two_beats", 64'(log_q.size() - base), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_after_rst", RVALID, 1'b0);
    chk("t6_arready_after_rst", ARREADY, 1'b1);
    @(posedge clk); #1;
    chk("t6_no_more_beats", 64'(log_q.size() - base), 64'd2);
    start_ar(32'h30, 8'd1, 3'b010, 2'b01);
    drain(16'b01, 2);
    lit("t6_b0", base + 2, 32'hC0DE000C, 2'b00, 1'b0);
    lit("t6_b1", base + 3, 32'hC0DE000D, 2'b00, 1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
